// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: owns the PC, steps each instruction through
// FETCH/DECODE/EXEC/[MEM]/WB and drives the fetch/decode stage's control strobes.
module control_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [63:0] doutA,
  output logic [31:0] PC_add,
  output logic        PC_load,
  output logic        WE_reg,
  output logic        WE_mem,
  output logic [1:0]  OP_MEM_I,
  output logic        ADD_SUB,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_INIT   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [6:0]  OPC_R      = 7'b0110011;
  localparam logic [6:0]  OPC_ADDI   = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] IR_ECALL   = 32'h0000_0073;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic        taken_reg;
  logic [15:0] retired_reg;

  logic        is_r, is_i, is_l, is_s, is_b;
  logic        branch_cond;
  logic [31:0] imm_b;
  logic [31:0] next_pc;

  assign is_r = (ir_reg[6:0] == OPC_R);
  assign is_i = (ir_reg[6:0] == OPC_ADDI);
  assign is_l = (ir_reg[6:0] == OPC_LOAD);
  assign is_s = (ir_reg[6:0] == OPC_STORE);
  assign is_b = (ir_reg[6:0] == OPC_BRANCH);

  // Only funct3 000 (beqz) and 001 (bnez) can ever be taken; IR[12] inverts the zero test.
  assign branch_cond = (ir_reg[14:13] == 2'b00) && ((doutA == 64'd0) ^ ir_reg[12]);

  assign imm_b   = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
  assign next_pc = pc_reg + ((is_b && taken_reg) ? imm_b : PC_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_RST;
      pc_reg      <= RESET_PC;
      ir_reg      <= 32'd0;
      taken_reg   <= 1'b0;
      retired_reg <= 16'd0;
    end else begin
      case (state_reg)
        S_RST:  state_reg <= S_INIT;
        S_INIT: begin
          pc_reg    <= RESET_PC;
          state_reg <= S_FETCH;
        end
        S_FETCH: begin
          ir_reg    <= instruction;
          state_reg <= S_DECODE;
        end
        S_DECODE: state_reg <= (ir_reg == IR_ECALL) ? S_HALT : S_EXEC;
        S_EXEC: begin
          // doutA is only looked at on this edge; later changes cannot redirect the branch.
          taken_reg <= branch_cond;
          state_reg <= is_l ? S_MEM : S_WB;
        end
        S_MEM: state_reg <= S_WB;
        S_WB: begin
          pc_reg <= next_pc;
          if (retired_reg != 16'hFFFF)
            retired_reg <= retired_reg + 16'd1;
          state_reg <= S_FETCH;
        end
        S_HALT:  state_reg <= S_HALT;
        default: state_reg <= S_RST;
      endcase
    end
  end

  // Outputs decode straight from state and IR so an async reset kills strobes at once.
  always_comb begin
    PC_add   = 32'd0;
    PC_load  = 1'b0;
    WE_reg   = 1'b0;
    WE_mem   = 1'b0;
    OP_MEM_I = 2'b00;
    ADD_SUB  = 1'b0;
    if (state_reg == S_EXEC || state_reg == S_MEM || state_reg == S_WB) begin
      if (is_i)      OP_MEM_I = 2'b01;
      else if (is_l) OP_MEM_I = 2'b10;
      else if (is_s) OP_MEM_I = 2'b11;
      ADD_SUB = is_r & ir_reg[30];
    end
    if (state_reg == S_INIT) begin
      PC_load = 1'b1;
      PC_add  = RESET_PC;
    end
    if (state_reg == S_WB) begin
      PC_load = 1'b1;
      PC_add  = next_pc;
      WE_reg  = (is_r || is_i || is_l) && (ir_reg[11:7] != 5'd0);
      WE_mem  = is_s;
    end
  end

  assign halted  = (state_reg == S_HALT);
  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed vector table, randomized
// instructions against a per-instruction reference model, and reset/halt sequences.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic [63:0] doutA;
  logic [31:0] PC_add;
  logic        PC_load;
  logic        WE_reg;
  logic        WE_mem;
  logic [1:0]  OP_MEM_I;
  logic        ADD_SUB;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] retired;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .doutA(doutA),
    .PC_add(PC_add), .PC_load(PC_load), .WE_reg(WE_reg), .WE_mem(WE_mem),
    .OP_MEM_I(OP_MEM_I), .ADD_SUB(ADD_SUB), .halted(halted), .state(state),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] douta;
    logic [31:0] pc_add;
    logic        we_reg;
    logic        we_mem;
    logic [1:0]  op;
    logic        as;
    logic        is_load;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_pc;
  logic [15:0] exp_retired;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, ".PC_load"}, PC_load, 0);
    chk({nm, ".WE_reg"},  WE_reg,  0);
    chk({nm, ".WE_mem"},  WE_mem,  0);
  endtask

  // Reference model: what one instruction should do, from the ISA rules alone.
  function automatic vec_t model(input logic [31:0] ins, input logic [63:0] d,
                                 input logic [31:0] pc);
    vec_t v;
    logic signed [12:0] imm13;
    logic take;
    v.instr = ins; v.douta = d; v.we_reg = 0; v.we_mem = 0;
    v.op = 2'b00; v.as = 0; v.is_load = 0;
    take = 0;
    case (ins[6:0])
      7'b0110011: begin v.as = ins[30]; v.we_reg = (ins[11:7] != 0); end
      7'b0010011: begin v.op = 2'b01; v.we_reg = (ins[11:7] != 0); end
      7'b0000011: begin v.op = 2'b10; v.we_reg = (ins[11:7] != 0); v.is_load = 1; end
      7'b0100011: begin v.op = 2'b11; v.we_mem = 1; end
      7'b1100011: begin
        if (ins[14:12] == 3'b000) take = (d == 0);
        else if (ins[14:12] == 3'b001) take = (d != 0);
      end
      default: ;
    endcase
    imm13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    v.pc_add = take ? pc + 32'(int'(imm13)) : pc + 32'd4;
    return v;
  endfunction

  // Called just after a falling edge with the DUT expected in FETCH; returns in the next FETCH.
  task automatic do_instr(input string tag, input vec_t r);
    logic [31:0] junk;
    chk({tag, ".state_fetch"}, state, 3'd2);
    chk_quiet({tag, ".fetch"});
    instruction = r.instr;
    doutA       = r.douta;
    @(negedge clk);
    chk({tag, ".state_decode"}, state, 3'd3);
    junk = $urandom();
    instruction = junk;
    @(negedge clk);
    chk({tag, ".state_exec"}, state, 3'd4);
    chk({tag, ".exec_op"}, OP_MEM_I, r.op);
    chk({tag, ".exec_as"}, ADD_SUB, r.as);
    chk_quiet({tag, ".exec"});
    if (r.is_load) begin
      @(negedge clk);
      chk({tag, ".state_mem"}, state, 3'd5);
      chk({tag, ".mem_op"}, OP_MEM_I, r.op);
      chk_quiet({tag, ".mem"});
    end
    @(negedge clk);
    chk({tag, ".state_wb"}, state, 3'd6);
    chk({tag, ".wb_PC_load"}, PC_load, 1);
    chk({tag, ".wb_PC_add"}, PC_add, r.pc_add);
    chk({tag, ".wb_WE_reg"}, WE_reg, r.we_reg);
    chk({tag, ".wb_WE_mem"}, WE_mem, r.we_mem);
    chk({tag, ".wb_op"}, OP_MEM_I, r.op);
    chk({tag, ".wb_as"}, ADD_SUB, r.as);
    $display("%s instr=%08h doutA=%0h PC_add=%08h WE_reg=%0b WE_mem=%0b OP=%0d AS=%0b",
             tag, r.instr, r.douta, PC_add, WE_reg, WE_mem, OP_MEM_I, ADD_SUB);
    doutA = {$urandom(), $urandom()};
    if (exp_retired != 16'hFFFF) exp_retired++;
    @(negedge clk);
    chk({tag, ".retired"}, retired, exp_retired);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init.state", state, 3'd1);
    chk("init.PC_load", PC_load, 1);
    chk("init.PC_add", PC_add, 32'd0);
    chk("init.WE_reg", WE_reg, 0);
    @(negedge clk);
    model_pc = 32'd0;
    exp_retired = 16'd0;
  endtask

  vec_t tbl[12];

  initial begin
    vec_t v;
    logic [31:0] rnd;
    logic [6:0]  opc;
    logic [15:0] ret_hold;

    tbl[0]  = '{32'h002081B3, 64'd0, 32'd4,  1'b1, 1'b0, 2'b00, 1'b0, 1'b0}; // add
    tbl[1]  = '{32'h402081B3, 64'd0, 32'd8,  1'b1, 1'b0, 2'b00, 1'b1, 1'b0}; // sub
    tbl[2]  = '{32'h0020B023, 64'd0, 32'd12, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0}; // sd
    tbl[3]  = '{32'h0080B283, 64'd0, 32'd16, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1}; // ld
    tbl[4]  = '{32'hFE008CE3, 64'd0, 32'd8,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0}; // beqz taken
    tbl[5]  = '{32'h0000007F, 64'd0, 32'd12, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}; // unknown
    tbl[6]  = '{32'h00100013, 64'd0, 32'd16, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0}; // addi x0
    tbl[7]  = '{32'hFE008CE3, 64'd5, 32'd20, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}; // beqz not taken
    tbl[8]  = '{32'hFE009CE3, 64'd5, 32'd12, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}; // bnez taken
    tbl[9]  = '{32'h0FF00393, 64'd0, 32'd16, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0}; // addi x7
    tbl[10] = '{32'hFE009CE3, 64'd5, 32'd8,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0}; // bnez at 16
    tbl[11] = '{32'hFE00CCE3, 64'd0, 32'd12, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}; // funct3 100

    rst_n = 1'b0;
    instruction = 32'h002081B3;
    doutA = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst.state", state, 3'd0);
    chk("rst.PC_load", PC_load, 0);
    chk("rst.PC_add", PC_add, 32'd0);
    chk("rst.WE_reg", WE_reg, 0);
    chk("rst.WE_mem", WE_mem, 0);
    chk("rst.halted", halted, 0);
    chk("rst.retired", retired, 16'd0);
    release_reset();

    for (int i = 0; i < 12; i++) begin
      do_instr($sformatf("vec%0d", i), tbl[i]);
      model_pc = tbl[i].pc_add;
    end

    for (int i = 0; i < 200; i++) begin
      rnd = $urandom();
      case ($urandom_range(0, 5))
        0: opc = 7'b0110011;
        1: opc = 7'b0010011;
        2: opc = 7'b0000011;
        3: opc = 7'b0100011;
        4: begin
          opc = 7'b1100011;
          if ($urandom_range(0, 3) != 0) rnd[14:13] = 2'b00;
        end
        default: opc = 7'($urandom_range(0, 127));
      endcase
      rnd[6:0] = opc;
      if (rnd == 32'h0000_0073) rnd = 32'h0000_0013;
      v = model(rnd, ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom(), $urandom()}, model_pc);
      do_instr($sformatf("rnd%0d", i), v);
      model_pc = v.pc_add;
    end

    // ecall: halt and stay halted with no PC loads
    ret_hold = exp_retired;
    chk("halt.state_fetch", state, 3'd2);
    instruction = 32'h0000_0073;
    @(negedge clk);
    chk("halt.state_decode", state, 3'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt.state", state, 3'd7);
      chk("halt.halted", halted, 1);
      chk("halt.PC_load", PC_load, 0);
    end
    chk("halt.retired", retired, ret_hold);
    $display("halt held for 20 cycles, retired=%0d", retired);

    // Reset out of HALT, then abort a store in WB with reset
    rst_n = 1'b0;
    #1;
    chk("halt_rst.state", state, 3'd0);
    release_reset();
    instruction = 32'h0020B023;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort.state_wb", state, 3'd6);
    chk("abort.WE_mem_before", WE_mem, 1);
    rst_n = 1'b0;
    #1;
    chk("abort.WE_mem_after", WE_mem, 0);
    chk("abort.PC_load_after", PC_load, 0);
    chk("abort.state", state, 3'd0);
    chk("abort.retired", retired, 16'd0);
    $display("reset during store WB: WE_mem=%0b state=%0d", WE_mem, state);
    release_reset();

    v = model(32'h002081B3, 64'd0, model_pc);
    do_instr("restart_add", v);
    model_pc = v.pc_add;
    // Negative branch from pc 4 wraps to the top of the address space, then back to 0
    v = '{32'hFE008CE3, 64'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    do_instr("wrap_branch", v);
    v = '{32'h0000007F, 64'd0, 32'h0000_0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    do_instr("wrap_step", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
